// File: rtl/lms_pkg.sv
// Shared Q-format helpers and FSM state encoding for the LMS weight-update path.
package lms_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } lms_state_e;

   localparam int QP_DEF = 12;

   function automatic logic signed [63:0] round_half(input int qp);
      round_half = 64'sd1 <<< (qp - 1);
   endfunction

   localparam logic signed [63:0] ROUND_HALF = round_half(QP_DEF);

   // Clamp a wide signed value into the two's-complement range of 'width' bits.
   function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (v > hi) begin
         sat_to_width = hi;
      end else if (v < lo) begin
         sat_to_width = lo;
      end else begin
         sat_to_width = v;
      end
   endfunction

endpackage

// File: rtl/lms_weight_bank_if.sv
// Bus between the error/step-size stage, the FIR stage and the LMS weight bank.
interface lms_weight_bank_if #(
   parameter int WIDTH = 16,
   parameter int TAPS  = 8,
   parameter int AW    = $clog2(TAPS)
);
   logic signed [WIDTH-1:0]      x_in;
   logic                         x_valid;
   logic                         x_ready;
   logic signed [WIDTH-1:0]      mu_error;
   logic                         start;
   logic                         clear;
   logic                         busy;
   logic                         done;
   logic [AW-1:0]                rd_addr;
   logic signed [WIDTH-1:0]      rd_weight;
   logic [TAPS*WIDTH-1:0]        x_tap;

   modport master (
      output x_in, x_valid, mu_error, start, clear, rd_addr,
      input  x_ready, busy, done, rd_weight, x_tap
   );

   modport slave (
      input  x_in, x_valid, mu_error, start, clear, rd_addr,
      output x_ready, busy, done, rd_weight, x_tap
   );
endinterface

// File: rtl/w_update_mac.sv
// Stage-2 weight update: round the product to Q format, optionally saturate, add to the weight.
module w_update_mac
   import lms_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int QP    = 12,
   parameter int SAT   = 1
) (
   input  logic signed [2*WIDTH-1:0] prod,
   input  logic signed [WIDTH-1:0]   w_old,
   output logic signed [WIDTH-1:0]   w_new
);

   logic signed [63:0] prod_x_s;
   logic signed [63:0] rnd_s;
   logic signed [63:0] shr_s;
   logic signed [63:0] d_s;
   logic signed [63:0] sum_s;

   // Wide arithmetic keeps the low bits identical to the narrow wrap behaviour.
   always_comb begin
      prod_x_s = 64'(prod);
      rnd_s    = prod_x_s + round_half(QP);
      shr_s    = rnd_s >>> QP;
      if (SAT != 0) begin
         d_s   = sat_to_width(shr_s, WIDTH);
         sum_s = 64'(w_old) + d_s;
         w_new = WIDTH'(sat_to_width(sum_s, WIDTH));
      end else begin
         d_s   = 64'($signed(rnd_s[QP +: WIDTH]));
         sum_s = 64'(w_old) + d_s;
         w_new = WIDTH'(sum_s);
      end
   end

endmodule

// File: rtl/lms_weight_bank.sv
// TAPS-deep delay line plus weight bank, updated serially by one shared 2-stage multiply/accumulate.
module lms_weight_bank
   import lms_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int QP    = 12,
   parameter int TAPS  = 8,
   parameter int SAT   = 1,
   parameter int AW    = $clog2(TAPS)
) (
   input  logic             clk,
   input  logic             reset,
   lms_weight_bank_if.slave bus
);

   lms_state_e                state_r;
   lms_state_e                state_s;
   logic                      start_pass_s;
   logic                      done_set_s;
   logic                      busy_s;
   logic                      accept_s;

   logic [AW-1:0]             idx_r;
   logic [AW-1:0]             idx_d_r;
   logic signed [WIDTH-1:0]   mu_r;
   logic signed [2*WIDTH-1:0] prod_r;
   logic                      prod_vld_r;
   logic                      done_r;
   logic signed [WIDTH-1:0]   tap_r [TAPS];
   logic signed [WIDTH-1:0]   w_r   [TAPS];
   logic signed [WIDTH-1:0]   w_new_s;

   assign busy_s   = (state_r != IDLE);
   assign accept_s = bus.x_valid & ~busy_s;

   // Next-state logic; clear always wins over start and aborts a running pass.
   always_comb begin
      state_s      = state_r;
      start_pass_s = 1'b0;
      done_set_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.clear) begin
               state_s = IDLE;
            end else if (bus.start) begin
               state_s      = RUN;
               start_pass_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (bus.clear) begin
               state_s = IDLE;
            end else if (idx_r == AW'(TAPS - 1)) begin
               state_s    = DRAIN;
               done_set_s = 1'b1;
            end else begin
               state_s = RUN;
            end
         end
         DRAIN: state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Stage 1: tap index walk and product register. The delay line is frozen while
   // busy, so a sample accepted on the start edge is already at tap 0 for idx 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_r      <= '0;
         idx_d_r    <= '0;
         mu_r       <= '0;
         prod_r     <= '0;
         prod_vld_r <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         done_r     <= done_set_s;
         mu_r       <= start_pass_s ? bus.mu_error : mu_r;
         idx_r      <= (state_r == RUN) ? idx_r + AW'(1) : '0;
         idx_d_r    <= idx_r;
         prod_r     <= (2*WIDTH)'(tap_r[idx_r]) * (2*WIDTH)'(mu_r);
         prod_vld_r <= (state_r == RUN) && !bus.clear;
      end
   end

   // Input delay line.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < TAPS; k++) tap_r[k] <= '0;
      end else if (accept_s) begin
         tap_r[0] <= bus.x_in;
         for (int k = 1; k < TAPS; k++) tap_r[k] <= tap_r[k-1];
      end
   end

   w_update_mac #(
      .WIDTH (WIDTH),
      .QP    (QP),
      .SAT   (SAT)
   ) u_mac (
      .prod  (prod_r),
      .w_old (w_r[idx_d_r]),
      .w_new (w_new_s)
   );

   // Stage 2 write-back into the weight bank; clear suppresses any in-flight write.
   always_ff @(posedge clk) begin
      if (reset || bus.clear) begin
         for (int k = 0; k < TAPS; k++) w_r[k] <= '0;
      end else if (prod_vld_r) begin
         w_r[idx_d_r] <= w_new_s;
      end
   end

   // Flatten the delay line for the FIR, tap 0 in the low bits.
   always_comb begin
      bus.x_tap = '0;
      for (int k = 0; k < TAPS; k++) bus.x_tap[k*WIDTH +: WIDTH] = tap_r[k];
   end

   assign bus.rd_weight = w_r[bus.rd_addr];
   assign bus.busy      = busy_s;
   assign bus.done      = done_r;
   assign bus.x_ready   = ~busy_s;

endmodule
